otter_cu_fsm: RTL and testbench
===============================

Name: otter_cu_fsm

Overview:
Multi-cycle control-unit state machine for the OTTER MCU. It sequences each instruction through fetch, execute, optional writeback and interrupt entry. It sits directly upstream of the program counter and drives its write enable (PC_WRITE) and reset (PC_RST), along with memory and register-file strobes. It also keeps a retired-instruction counter for debug.

Parameters:
INIT_HOLD, 1, number of cycles spent in INIT asserting RST_OUT after reset deasserts (1..15)

Ports:
FSM_CLK  input  1  system clock; all state updates on the rising edge
FSM_RST  input  1  synchronous, active-high reset
OPCODE  input  7  ir[6:0] of the current instruction
FUNC3  input  3  ir[14:12]
INTR  input  1  interrupt request, already gated by the CSR MIE bit, level-sensitive
RST_OUT  output  1  drives program counter PC_RST and register-file clear
PC_WRITE  output  1  program counter load enable
REG_WRITE  output  1  register-file write enable
MEM_RDEN1  output  1  instruction-memory read enable
MEM_RDEN2  output  1  data-memory read enable
MEM_WE2  output  1  data-memory write enable
CSR_WE  output  1  CSR write enable
INT_TAKEN  output  1  interrupt-entry strobe to CSR and PC-source mux
MRET_EXEC  output  1  mret strobe to CSR and PC-source mux
INSTR_RET  output  32  count of retired instructions

Behaviour:
- Reset: FSM_RST=1 at a rising edge forces state to INIT, clears the hold counter and sets INSTR_RET=0. Reset overrides every other input, including mid-instruction (e.g. in WB or INTR).
- State encoding: INIT, FETCH, EXEC, WB, INTR. A registered state machine with a 4-bit hold counter.
- Outputs are decoded combinationally from the state (plus OPCODE/FUNC3 in EXEC). Every output not listed below is 0 in that state.
- INIT:
  - RST_OUT=1.
  - Stays in INIT for INIT_HOLD cycles after reset deasserts, then moves to FETCH.
  - In the cycle after FSM_RST deasserts, RST_OUT=1 and all other strobes are 0.
- FETCH:
  - MEM_RDEN1=1.
  - Next state is always EXEC.
  - INTR is ignored here.
- EXEC, decoded by OPCODE:
  - 0000011 (load): MEM_RDEN2=1; next state WB; no PC_WRITE.
  - 0100011 (store): MEM_WE2=1, PC_WRITE=1.
  - 1100011 (branch): PC_WRITE=1.
  - 0110011, 0010011, 0110111, 0010111, 1101111, 1100111: PC_WRITE=1, REG_WRITE=1.
  - 1110011 with FUNC3=000 (mret): PC_WRITE=1, MRET_EXEC=1.
  - 1110011 with FUNC3 in {001,010,011}: PC_WRITE=1, REG_WRITE=1, CSR_WE=1.
  - 1110011 with any other FUNC3, or any unlisted opcode: treated as a NOP; PC_WRITE=1 only.
  - Next state for every non-load case: INTR if INTR=1, else FETCH.
- WB:
  - REG_WRITE=1, PC_WRITE=1.
  - Next state: INTR if INTR=1, else FETCH.
- INTR:
  - INT_TAKEN=1, PC_WRITE=1.
  - Next state is always FETCH. Nested entry is impossible because INTR is not sampled in FETCH.
- INTR is sampled only on the edge that leaves EXEC (non-load) or WB.
  - A pulse confined to FETCH, or to EXEC of a load, is missed; the source must hold it.
  - An mret and an interrupt in the same EXEC: mret strobes fire, then INTR is entered.
- INSTR_RET:
  - Increments by 1 on each edge that leaves EXEC with PC_WRITE=1, or leaves WB.
  - Does not increment for INTR.
  - Wraps from 0xFFFFFFFF to 0; no saturation.
- Exactly one PC_WRITE pulse occurs per instruction, plus one per interrupt entry.
- RST_OUT and PC_WRITE are never both 1.

Test Plan:
- Reset, then 3 cycles: FSM_RST high for 2 cycles with INIT_HOLD=1 -> RST_OUT=1 for 1 cycle after release, then MEM_RDEN1=1, then EXEC; INSTR_RET=0.
- OPCODE=0110011 stream of 4 instructions -> state sequence FETCH,EXEC repeated 4 times; PC_WRITE and REG_WRITE high on each EXEC; INSTR_RET=4.
- OPCODE=0000011 -> EXEC has MEM_RDEN2=1 and PC_WRITE=0; WB has REG_WRITE=1 and PC_WRITE=1; one retire; a store (0100011) gives MEM_WE2=1 and PC_WRITE=1 in a single EXEC.
- INTR=1 held during EXEC of an add -> next state INTR with INT_TAKEN=1 and PC_WRITE=1, then FETCH; INSTR_RET increments once, not twice. INTR pulsed only in FETCH -> no INTR state.
- OPCODE=1110011, FUNC3=000 with INTR=1 -> MRET_EXEC=1 in EXEC, then INTR state. FUNC3=001 -> CSR_WE=1 and REG_WRITE=1. OPCODE=1111111 -> PC_WRITE=1 only.
- FSM_RST asserted during WB -> next edge in INIT, REG_WRITE=0, INSTR_RET=0. Preload INSTR_RET=0xFFFFFFFF via a long run or force, retire once -> INSTR_RET=0.

Source files
------------

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bus: instruction fields and interrupt in, datapath strobes and retire count out.
// Latency: none; this is a plain bundle of wires.
// Backpressure: none; strobes are single-cycle and unconditionally accepted.
interface otter_cu_fsm_if;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNC3;
    logic        INTR;
    logic        RST_OUT;
    logic        PC_WRITE;
    logic        REG_WRITE;
    logic        MEM_RDEN1;
    logic        MEM_RDEN2;
    logic        MEM_WE2;
    logic        CSR_WE;
    logic        INT_TAKEN;
    logic        MRET_EXEC;
    logic [31:0] INSTR_RET;

    // Master drives the instruction fields and interrupt request.
    modport master (
        output OPCODE, FUNC3, INTR,
        input  RST_OUT, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2,
               MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC, INSTR_RET
    );

    // Slave is the control unit itself.
    modport slave (
        input  OPCODE, FUNC3, INTR,
        output RST_OUT, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2,
               MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC, INSTR_RET
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multi-cycle control unit: INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Latency: strobes are combinational from the current state (and opcode in EXEC); state moves every cycle.
// Backpressure: none; interrupt request is only sampled when leaving EXEC (non-load) or WB.
module otter_cu_fsm #(
    parameter int unsigned INIT_HOLD = 1
) (
    input  logic          FSM_CLK,
    input  logic          FSM_RST,
    otter_cu_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [3:0] HOLD_LAST = 4'(INIT_HOLD - 1);

    state_t      state, state_nxt;
    logic [3:0]  hold_cnt, hold_nxt;
    logic [31:0] instr_ret;
    logic        retire;

    logic rst_out, pc_write, reg_write, mem_rden1, mem_rden2;
    logic mem_we2, csr_we, int_taken, mret_exec;

    // Next-state and strobe decode; every strobe defaults low.
    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        rst_out   = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        case (state)
            ST_INIT: begin
                rst_out = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_FETCH;
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = bus.INTR ? ST_INTR : ST_FETCH;
                case (bus.OPCODE)
                    OP_LOAD: begin
                        mem_rden2 = 1'b1;
                        state_nxt = ST_WB;
                    end
                    OP_STORE: begin
                        mem_we2  = 1'b1;
                        pc_write = 1'b1;
                    end
                    OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                    end
                    OP_SYS: begin
                        pc_write = 1'b1;
                        if (bus.FUNC3 == 3'b000) begin
                            mret_exec = 1'b1;
                        end else if (bus.FUNC3 == 3'b001 || bus.FUNC3 == 3'b010 ||
                                     bus.FUNC3 == 3'b011) begin
                            reg_write = 1'b1;
                            csr_we    = 1'b1;
                        end
                    end
                    // Branches and unknown opcodes only advance the PC.
                    default: pc_write = 1'b1;
                endcase
                if (bus.OPCODE == OP_BRANCH) pc_write = 1'b1;
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_nxt = bus.INTR ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // An instruction retires on its single PC update; interrupt entry does not count.
    assign retire = (state == ST_EXEC && pc_write) || (state == ST_WB);

    // State, hold counter and retire counter; reset wins over everything.
    always_ff @(posedge FSM_CLK) begin
        if (FSM_RST) begin
            state     <= ST_INIT;
            hold_cnt  <= '0;
            instr_ret <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            instr_ret <= instr_ret + {31'd0, retire};
        end
    end

    assign bus.RST_OUT   = rst_out;
    assign bus.PC_WRITE  = pc_write;
    assign bus.REG_WRITE = reg_write;
    assign bus.MEM_RDEN1 = mem_rden1;
    assign bus.MEM_RDEN2 = mem_rden2;
    assign bus.MEM_WE2   = mem_we2;
    assign bus.CSR_WE    = csr_we;
    assign bus.INT_TAKEN = int_taken;
    assign bus.MRET_EXEC = mret_exec;
    assign bus.INSTR_RET = instr_ret;
endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: per-cycle directed vectors with hand-computed strobes queued for a monitor.
// Latency: expected values describe the outputs during the same cycle the inputs are applied.
// Backpressure: not applicable; the monitor checks one queued entry per cycle.
module tb_otter_cu_fsm;
    typedef struct packed {
        logic        rst_out;
        logic        pc_write;
        logic        reg_write;
        logic        rden1;
        logic        rden2;
        logic        we2;
        logic        csr_we;
        logic        int_taken;
        logic        mret;
        logic [31:0] ret;
    } exp_t;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] SYS  = 7'b1110011;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic FSM_CLK = 1'b0;
    logic FSM_RST = 1'b1;
    otter_cu_fsm_if bus ();

    otter_cu_fsm #(.INIT_HOLD(1)) dut (
        .FSM_CLK (FSM_CLK),
        .FSM_RST (FSM_RST),
        .bus     (bus.slave)
    );

    always #5 FSM_CLK = ~FSM_CLK;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;
    bit   stim_done = 1'b0;

    // Expected strobe vector: r=RST_OUT p=PC_WRITE w=REG_WRITE f=RDEN1 l=RDEN2 s=WE2 c=CSR_WE i=INT_TAKEN m=MRET
    function automatic exp_t mk(input logic r, p, w, f, l, s, c, i, m, input logic [31:0] ret);
        exp_t e;
        e = '{rst_out:r, pc_write:p, reg_write:w, rden1:f, rden2:l, we2:s,
              csr_we:c, int_taken:i, mret:m, ret:ret};
        return e;
    endfunction

    function automatic exp_t e_init(input logic [31:0] ret);
        return mk(1,0,0,0,0,0,0,0,0, ret);
    endfunction
    function automatic exp_t e_fetch(input logic [31:0] ret);
        return mk(0,0,0,1,0,0,0,0,0, ret);
    endfunction
    function automatic exp_t e_alu(input logic [31:0] ret);
        return mk(0,1,1,0,0,0,0,0,0, ret);
    endfunction
    function automatic exp_t e_load(input logic [31:0] ret);
        return mk(0,0,0,0,1,0,0,0,0, ret);
    endfunction
    function automatic exp_t e_wb(input logic [31:0] ret);
        return mk(0,1,1,0,0,0,0,0,0, ret);
    endfunction
    function automatic exp_t e_intr(input logic [31:0] ret);
        return mk(0,1,0,0,0,0,0,1,0, ret);
    endfunction
    function automatic exp_t e_pconly(input logic [31:0] ret);
        return mk(0,1,0,0,0,0,0,0,0, ret);
    endfunction

    // Apply one cycle of inputs just after the edge and queue what the outputs must be this cycle.
    task automatic step(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                        input logic intr, input exp_t e);
        @(posedge FSM_CLK);
        #1;
        FSM_RST    = rst;
        bus.OPCODE = op;
        bus.FUNC3  = f3;
        bus.INTR   = intr;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per queued cycle, sampled on the falling edge.
    initial begin
        exp_t got;
        exp_t want;
        forever begin
            @(negedge FSM_CLK);
            if (exp_q.size() != 0) begin
                cyc_no++;
                want = exp_q.pop_front();
                got  = '{rst_out:bus.RST_OUT, pc_write:bus.PC_WRITE, reg_write:bus.REG_WRITE,
                         rden1:bus.MEM_RDEN1, rden2:bus.MEM_RDEN2, we2:bus.MEM_WE2,
                         csr_we:bus.CSR_WE, int_taken:bus.INT_TAKEN, mret:bus.MRET_EXEC,
                         ret:bus.INSTR_RET};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL cycle%0d strobes: got rst=%b pcw=%b regw=%b rd1=%b rd2=%b we2=%b csr=%b int=%b mret=%b ret=%h, want rst=%b pcw=%b regw=%b rd1=%b rd2=%b we2=%b csr=%b int=%b mret=%b ret=%h",
                             cyc_no, got.rst_out, got.pc_write, got.reg_write, got.rden1, got.rden2,
                             got.we2, got.csr_we, got.int_taken, got.mret, got.ret,
                             want.rst_out, want.pc_write, want.reg_write, want.rden1, want.rden2,
                             want.we2, want.csr_we, want.int_taken, want.mret, want.ret);
                end
                n_checks++;
                if (bus.RST_OUT === 1'b1 && bus.PC_WRITE === 1'b1) begin
                    n_fail++;
                    $display("FAIL cycle%0d rst_pcw_exclusive: got both 1, want not both", cyc_no);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        bus.OPCODE = ADD;
        bus.FUNC3  = 3'b000;
        bus.INTR   = 1'b0;
        @(posedge FSM_CLK);
        // Reset high for two edges, then release.
        step(1, ADD, 3'b000, 0, e_init(0));
        step(0, ADD, 3'b000, 0, e_init(0));
        step(0, ADD, 3'b000, 0, e_fetch(0));
        // Four ALU instructions.
        step(0, ADD, 3'b000, 0, e_alu(0));
        step(0, ADD, 3'b000, 0, e_fetch(1));
        step(0, ADD, 3'b000, 0, e_alu(1));
        step(0, ADD, 3'b000, 0, e_fetch(2));
        step(0, ADD, 3'b000, 0, e_alu(2));
        step(0, ADD, 3'b000, 0, e_fetch(3));
        step(0, ADD, 3'b000, 0, e_alu(3));
        step(0, LD,  3'b000, 0, e_fetch(4));
        // Load goes through WB and retires once.
        step(0, LD,  3'b000, 0, e_load(4));
        step(0, LD,  3'b000, 0, e_wb(4));
        step(0, ST,  3'b000, 0, e_fetch(5));
        // Store.
        step(0, ST,  3'b000, 0, mk(0,1,0,0,0,1,0,0,0, 5));
        step(0, ADD, 3'b000, 0, e_fetch(6));
        // Interrupt held during an ALU EXEC.
        step(0, ADD, 3'b000, 1, e_alu(6));
        step(0, ADD, 3'b000, 0, e_intr(7));
        // Interrupt pulse confined to FETCH is ignored.
        step(0, ADD, 3'b000, 1, e_fetch(7));
        step(0, ADD, 3'b000, 0, e_alu(7));
        step(0, SYS, 3'b000, 0, e_fetch(8));
        // mret with a pending interrupt.
        step(0, SYS, 3'b000, 1, mk(0,1,0,0,0,0,0,0,1, 8));
        step(0, SYS, 3'b001, 0, e_intr(9));
        step(0, SYS, 3'b001, 0, e_fetch(9));
        // CSR access.
        step(0, SYS, 3'b001, 0, mk(0,1,1,0,0,0,1,0,0, 9));
        step(0, BAD, 3'b000, 0, e_fetch(10));
        // Unknown opcode and system op with a non-CSR FUNC3 act as NOPs.
        step(0, BAD, 3'b000, 0, e_pconly(10));
        step(0, SYS, 3'b100, 0, e_fetch(11));
        step(0, SYS, 3'b100, 0, e_pconly(11));
        step(0, LD,  3'b000, 0, e_fetch(12));
        // Interrupt pulse confined to a load EXEC is missed.
        step(0, LD,  3'b000, 1, e_load(12));
        step(0, LD,  3'b000, 0, e_wb(12));
        step(0, LD,  3'b000, 0, e_fetch(13));
        // Reset asserted during WB.
        step(0, LD,  3'b000, 0, e_load(13));
        step(1, LD,  3'b000, 0, e_wb(13));
        step(0, ADD, 3'b000, 0, e_init(0));
        step(0, ADD, 3'b000, 0, e_fetch(0));
        step(0, ADD, 3'b000, 0, e_alu(0));
        // Preload the retire counter to its maximum and retire once to wrap.
        @(posedge FSM_CLK);
        #1;
        FSM_RST    = 1'b0;
        bus.OPCODE = ADD;
        bus.INTR   = 1'b0;
        force dut.instr_ret = 32'hFFFF_FFFF;
        #1;
        release dut.instr_ret;
        exp_q.push_back(e_fetch(32'hFFFF_FFFF));
        step(0, ADD, 3'b000, 0, e_alu(32'hFFFF_FFFF));
        step(0, LD,  3'b000, 0, e_fetch(0));
        // Interrupt sampled on leaving WB.
        step(0, LD,  3'b000, 0, e_load(0));
        step(0, ADD, 3'b000, 1, e_wb(0));
        step(0, ADD, 3'b000, 0, e_intr(1));
        step(0, ADD, 3'b000, 0, e_fetch(1));
        @(negedge FSM_CLK);
        @(negedge FSM_CLK);
        stim_done = 1'b1;
    end

    // End of run, with a bounded wait for the monitor to drain the queue.
    initial begin
        int budget;
        budget = 2000;
        while (!stim_done && budget > 0) begin
            @(posedge FSM_CLK);
            budget--;
        end
        n_checks++;
        if (!stim_done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got done=%0b pending=%0d, want done=1 pending=0",
                     stim_done, exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
